// File: rtl/ltssm_pkg.sv
// ltssm_pkg: shared ordered-set constants, ts_type encodings, symbol indices and receiver state type
package ltssm_pkg;
  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;
  localparam logic [7:0] PAD    = 8'hF7;
  localparam logic [1:0] TS_NONE  = 2'b00;
  localparam logic [1:0] TS_TYPE1 = 2'b01;
  localparam logic [1:0] TS_TYPE2 = 2'b10;
  localparam int SYM_COM  = 0;
  localparam int SYM_LINK = 1;
  localparam int SYM_LANE = 2;
  localparam int SYM_NFTS = 3;
  localparam int SYM_RATE = 4;
  localparam int SYM_CTRL = 5;
  localparam int SYM_ID0  = 6;
  localparam int SYM_LAST = 15;
  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCKED} rx_state_e;
endpackage

// File: rtl/ts_field_decode.sv
// ts_field_decode: combinational split of a 128-bit ordered set into fields plus good/type/malformed flags
// Ports: ts_i (in, 128) -> link_num..train_ctrl (symbols 1..5), good, malformed, ts_type (00 none, 01 TS1, 10 TS2)
module ts_field_decode
  import ltssm_pkg::*;
(
  input  logic [127:0] ts_i,
  output logic [7:0]   link_num,
  output logic [7:0]   lane_num,
  output logic [7:0]   n_fts,
  output logic [7:0]   rate_id,
  output logic [7:0]   train_ctrl,
  output logic         good,
  output logic         malformed,
  output logic [1:0]   ts_type
);
  logic all_ts1, all_ts2;
  always_comb begin
    all_ts1 = 1'b1;
    all_ts2 = 1'b1;
    for (int k = SYM_ID0; k <= SYM_LAST; k++) begin
      all_ts1 = all_ts1 & (ts_i[8*k +: 8] == TS1_ID);
      all_ts2 = all_ts2 & (ts_i[8*k +: 8] == TS2_ID);
    end
  end
  assign link_num   = ts_i[8*SYM_LINK +: 8];
  assign lane_num   = ts_i[8*SYM_LANE +: 8];
  assign n_fts      = ts_i[8*SYM_NFTS +: 8];
  assign rate_id    = ts_i[8*SYM_RATE +: 8];
  assign train_ctrl = ts_i[8*SYM_CTRL +: 8];
  assign good       = (ts_i[8*SYM_COM +: 8] == COM) && (all_ts1 || all_ts2);
  assign malformed  = !good;
  assign ts_type    = !good ? TS_NONE : all_ts1 ? TS_TYPE1 : TS_TYPE2;
endmodule

// File: rtl/ts_lane_receiver.sv
// ts_lane_receiver: per-lane TS1/TS2 receiver counting consecutive identical sets and reporting lock
// Ports: clk, rst (async, active-high), clear (sync flush), ts_i/ts_i_vld (received set),
//   ts_type, link_num, lane_num, n_fts, rate_id, train_ctrl (last good TS), consec_cnt (run length),
//   ts_lock (level), ts_lock_pulse, ts_err, gap_timeout (one-cycle pulses),
//   err_cnt (malformed count, only when TS_RX_ERR_CNT_EN is defined)
module ts_lane_receiver
  import ltssm_pkg::*;
#(
  parameter int REQ_CNT     = 8,
  parameter int CNT_W       = 4,
  parameter int GAP_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [127:0]     ts_i,
  input  logic             ts_i_vld,
  output logic [1:0]       ts_type,
  output logic [7:0]       link_num,
  output logic [7:0]       lane_num,
  output logic [7:0]       n_fts,
  output logic [7:0]       rate_id,
  output logic [7:0]       train_ctrl,
  output logic [CNT_W-1:0] consec_cnt,
  output logic             ts_lock,
  output logic             ts_lock_pulse,
  output logic             ts_err,
`ifdef TS_RX_ERR_CNT_EN
  output logic [15:0]      err_cnt,
`endif
  output logic             gap_timeout
);
  localparam int WD_W = $clog2(GAP_TIMEOUT + 1);
  rx_state_e state;
  logic [WD_W-1:0] wd;
  logic [7:0] d_link, d_lane, d_nfts, d_rate, d_ctrl;
  logic [1:0] d_type;
  logic d_good, d_bad, same, expire;
  logic [CNT_W-1:0] cnt_n;
  ts_field_decode u_dec (
    .ts_i(ts_i), .link_num(d_link), .lane_num(d_lane), .n_fts(d_nfts), .rate_id(d_rate),
    .train_ctrl(d_ctrl), .good(d_good), .malformed(d_bad), .ts_type(d_type)
  );
  // Identity is only meaningful against a held TS, i.e. outside IDLE
  assign same = (state != S_IDLE) && (d_type == ts_type) && (d_link == link_num) && (d_lane == lane_num)
             && (d_nfts == n_fts) && (d_rate == rate_id) && (d_ctrl == train_ctrl);
  assign cnt_n = !same ? CNT_W'(1) : (consec_cnt == {CNT_W{1'b1}}) ? consec_cnt : consec_cnt + 1'b1;
  assign expire = (wd == WD_W'(GAP_TIMEOUT - 1));
  assign ts_lock = (state == S_LOCKED);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      wd            <= '0;
      consec_cnt    <= '0;
      ts_type       <= TS_NONE;
      link_num      <= '0;
      lane_num      <= '0;
      n_fts         <= '0;
      rate_id       <= '0;
      train_ctrl    <= '0;
      ts_lock_pulse <= 1'b0;
      ts_err        <= 1'b0;
      gap_timeout   <= 1'b0;
    end else begin
      ts_lock_pulse <= 1'b0;
      ts_err        <= 1'b0;
      gap_timeout   <= 1'b0;
      if (clear) begin
        state      <= S_IDLE;
        wd         <= '0;
        consec_cnt <= '0;
        ts_type    <= TS_NONE;
      end else if (ts_i_vld && d_good) begin
        wd            <= '0;
        ts_type       <= d_type;
        link_num      <= d_link;
        lane_num      <= d_lane;
        n_fts         <= d_nfts;
        rate_id       <= d_rate;
        train_ctrl    <= d_ctrl;
        consec_cnt    <= cnt_n;
        state         <= (cnt_n >= CNT_W'(REQ_CNT)) ? S_LOCKED : S_TRACK;
        ts_lock_pulse <= (cnt_n >= CNT_W'(REQ_CNT)) && (state != S_LOCKED);
      end else if (ts_i_vld && d_bad) begin
        wd         <= '0;
        ts_err     <= 1'b1;
        consec_cnt <= '0;
        state      <= S_IDLE;
      end else if (!ts_i_vld && state != S_IDLE) begin
        wd <= expire ? '0 : wd + 1'b1;
        if (expire) begin
          gap_timeout <= 1'b1;
          consec_cnt  <= '0;
          state       <= S_IDLE;
        end
      end
    end
  end
`ifdef TS_RX_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) err_cnt <= '0;
    else if (!clear && ts_i_vld && d_bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_ts_lane_receiver.sv
// tb_ts_lane_receiver: directed self-checking bench for ts_lane_receiver
module tb_ts_lane_receiver;
  logic clk = 0, rst = 1, clear = 0, ts_i_vld = 0;
  logic [127:0] ts_i = '0;
  logic [1:0] ts_type;
  logic [7:0] link_num, lane_num, n_fts, rate_id, train_ctrl;
  logic [3:0] consec_cnt;
  logic ts_lock, ts_lock_pulse, ts_err, gap_timeout;
`ifdef TS_RX_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  ts_lane_receiver dut (
    .clk(clk), .rst(rst), .clear(clear), .ts_i(ts_i), .ts_i_vld(ts_i_vld),
    .ts_type(ts_type), .link_num(link_num), .lane_num(lane_num), .n_fts(n_fts),
    .rate_id(rate_id), .train_ctrl(train_ctrl), .consec_cnt(consec_cnt),
    .ts_lock(ts_lock), .ts_lock_pulse(ts_lock_pulse), .ts_err(ts_err),
`ifdef TS_RX_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .gap_timeout(gap_timeout)
  );
  function automatic logic [127:0] mk(input logic [7:0] id, l, n, f, r, c);
    mk = {{10{id}}, c, r, f, n, l, 8'hBC};
  endfunction
  task automatic drive(input logic [127:0] t, input logic v, input logic c);
    @(negedge clk);
    ts_i = t;
    ts_i_vld = v;
    clear = c;
  endtask
  task automatic idle();
    drive(ts_i, 1'b0, 1'b0);
  endtask
  task automatic test_reset();
    checks++; if (ts_type !== 2'b00) begin errors++; $display("FAIL reset_type: got %0h want 0", ts_type); end
    checks++; if (consec_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", consec_cnt); end
    checks++; if ({link_num, lane_num, n_fts, rate_id, train_ctrl} !== 40'd0) begin errors++; $display("FAIL reset_fields: got %0h want 0", {link_num, lane_num, n_fts, rate_id, train_ctrl}); end
    checks++; if ({ts_lock, ts_lock_pulse, ts_err, gap_timeout} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {ts_lock, ts_lock_pulse, ts_err, gap_timeout}); end
`ifdef TS_RX_ERR_CNT_EN
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
`endif
  endtask
  task automatic test_lock();
    logic [127:0] t = mk(8'h4A, 8'h00, 8'h02, 8'h10, 8'h02, 8'h00);
    repeat (7) drive(t, 1'b1, 1'b0);
    idle();
    checks++; if (consec_cnt !== 4'd7) begin errors++; $display("FAIL lock_cnt7: got %0d want 7", consec_cnt); end
    checks++; if ({ts_lock, ts_lock_pulse} !== 2'b00) begin errors++; $display("FAIL lock_early: got %b want 00", {ts_lock, ts_lock_pulse}); end
    drive(t, 1'b1, 1'b0);
    idle();
    checks++; if ({ts_lock, ts_lock_pulse} !== 2'b11) begin errors++; $display("FAIL lock_rise: got %b want 11", {ts_lock, ts_lock_pulse}); end
    checks++; if (consec_cnt !== 4'd8) begin errors++; $display("FAIL lock_cnt8: got %0d want 8", consec_cnt); end
    checks++; if (lane_num !== 8'h02 || n_fts !== 8'h10 || rate_id !== 8'h02) begin errors++; $display("FAIL lock_fields: got lane %0h nfts %0h rate %0h want 2 10 2", lane_num, n_fts, rate_id); end
    checks++; if (ts_type !== 2'b01) begin errors++; $display("FAIL lock_type: got %0h want 1", ts_type); end
    drive(t, 1'b1, 1'b0);
    idle();
    checks++; if ({ts_lock, ts_lock_pulse} !== 2'b10) begin errors++; $display("FAIL lock_pulse_once: got %b want 10", {ts_lock, ts_lock_pulse}); end
    checks++; if (consec_cnt !== 4'd9) begin errors++; $display("FAIL lock_cnt9: got %0d want 9", consec_cnt); end
  endtask
  task automatic test_type_change();
    drive(ts_i, 1'b0, 1'b1);
    repeat (5) drive(mk(8'h4A, 8'h01, 8'h03, 8'h20, 8'h01, 8'h00), 1'b1, 1'b0);
    drive(mk(8'h45, 8'h01, 8'h03, 8'h20, 8'h01, 8'h00), 1'b1, 1'b0);
    idle();
    checks++; if (consec_cnt !== 4'd1) begin errors++; $display("FAIL type_cnt: got %0d want 1", consec_cnt); end
    checks++; if (ts_type !== 2'b10) begin errors++; $display("FAIL type_ts2: got %0h want 2", ts_type); end
    checks++; if (ts_lock !== 1'b0) begin errors++; $display("FAIL type_lock: got %b want 0", ts_lock); end
    drive(mk(8'h45, 8'h01, 8'h03, 8'h21, 8'h01, 8'h00), 1'b1, 1'b0);
    idle();
    checks++; if (consec_cnt !== 4'd1 || n_fts !== 8'h21) begin errors++; $display("FAIL type_field_change: got cnt %0d nfts %0h want 1 21", consec_cnt, n_fts); end
  endtask
  task automatic test_malformed();
    logic [127:0] t = mk(8'h4A, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09);
    logic [127:0] b = t;
    b[7:0] = 8'h00;
    drive(ts_i, 1'b0, 1'b1);
    repeat (4) drive(t, 1'b1, 1'b0);
    drive(b, 1'b1, 1'b0);
    idle();
    checks++; if (ts_err !== 1'b1) begin errors++; $display("FAIL mal_err: got %b want 1", ts_err); end
    checks++; if (consec_cnt !== 4'd0 || ts_lock !== 1'b0) begin errors++; $display("FAIL mal_cnt: got cnt %0d lock %b want 0 0", consec_cnt, ts_lock); end
    checks++; if (ts_type !== 2'b01 || link_num !== 8'h05 || train_ctrl !== 8'h09) begin errors++; $display("FAIL mal_hold: got type %0h link %0h ctrl %0h want 1 5 9", ts_type, link_num, train_ctrl); end
`ifdef TS_RX_ERR_CNT_EN
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL mal_errcnt: got %0d want 1", err_cnt); end
`endif
    idle();
    checks++; if (ts_err !== 1'b0) begin errors++; $display("FAIL mal_pulse_width: got %b want 0", ts_err); end
    b = t;
    b[127:120] = 8'h45;
    drive(b, 1'b1, 1'b0);
    idle();
    checks++; if (ts_err !== 1'b1) begin errors++; $display("FAIL mal_mixed_id: got %b want 1", ts_err); end
`ifdef TS_RX_ERR_CNT_EN
    checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL mal_errcnt2: got %0d want 2", err_cnt); end
`endif
    drive(t, 1'b1, 1'b0);
    idle();
    checks++; if (consec_cnt !== 4'd1 || ts_err !== 1'b0) begin errors++; $display("FAIL mal_recover: got cnt %0d err %b want 1 0", consec_cnt, ts_err); end
  endtask
  task automatic test_gap();
    drive(ts_i, 1'b0, 1'b1);
    repeat (3) drive(mk(8'h45, 8'h33, 8'h01, 8'h00, 8'h00, 8'h00), 1'b1, 1'b0);
    repeat (1024) idle();
    checks++; if (gap_timeout !== 1'b0 || consec_cnt !== 4'd3) begin errors++; $display("FAIL gap_early: got to %b cnt %0d want 0 3", gap_timeout, consec_cnt); end
    idle();
    checks++; if (gap_timeout !== 1'b1) begin errors++; $display("FAIL gap_pulse: got %b want 1", gap_timeout); end
    checks++; if (consec_cnt !== 4'd0 || link_num !== 8'h33) begin errors++; $display("FAIL gap_state: got cnt %0d link %0h want 0 33", consec_cnt, link_num); end
    idle();
    checks++; if (gap_timeout !== 1'b0) begin errors++; $display("FAIL gap_pulse_width: got %b want 0", gap_timeout); end
  endtask
  task automatic test_clear_collision();
    logic [127:0] t = mk(8'h4A, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(ts_i, 1'b0, 1'b1);
    repeat (8) drive(t, 1'b1, 1'b0);
    drive(t, 1'b1, 1'b1);
    idle();
    checks++; if ({ts_lock, ts_lock_pulse} !== 2'b00 || consec_cnt !== 4'd0) begin errors++; $display("FAIL clr_state: got lock %b cnt %0d want 0 0", ts_lock, consec_cnt); end
    checks++; if (ts_type !== 2'b00 || link_num !== 8'h44) begin errors++; $display("FAIL clr_type: got type %0h link %0h want 0 44", ts_type, link_num); end
    drive(t, 1'b1, 1'b0);
    idle();
    checks++; if (consec_cnt !== 4'd1 || ts_type !== 2'b01) begin errors++; $display("FAIL clr_restart: got cnt %0d type %0h want 1 1", consec_cnt, ts_type); end
  endtask
  task automatic test_saturate_reset();
    drive(ts_i, 1'b0, 1'b1);
    repeat (20) drive(mk(8'h4A, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E), 1'b1, 1'b0);
    idle();
    checks++; if (consec_cnt !== 4'd15 || ts_lock !== 1'b1) begin errors++; $display("FAIL sat: got cnt %0d lock %b want 15 1", consec_cnt, ts_lock); end
    @(negedge clk);
    #1 rst = 1;
    #1;
    checks++; if ({ts_lock, consec_cnt, ts_type} !== 7'd0 || {link_num, lane_num, n_fts, rate_id, train_ctrl} !== 40'd0) begin errors++; $display("FAIL async_rst: got lock %b cnt %0d type %0h link %0h want all 0", ts_lock, consec_cnt, ts_type, link_num); end
    @(negedge clk) rst = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 0;
    test_lock();
    test_type_change();
    test_malformed();
    test_gap();
    test_clear_collision();
    test_saturate_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ts_lane_receiver.md
# ts_lane_receiver

Per-lane training-sequence receiver for the LTSSM link model. Accepts the 128-bit ordered sets driven by the link partner's `laneN_ts_o`/`laneN_ts_o_vld`, validates and decodes them, and counts consecutive identical TS1/TS2 sets. It reports lock once the required run length is reached, which is the gating condition for Polling and Configuration state exits. One instance per lane sits on the receive side of each LTSSM.

## Interface
Parameters:
- `REQ_CNT`, 8: consecutive identical TS needed for lock.
- `CNT_W`, 4: width of the consecutive counter. Must satisfy `2**CNT_W - 1 >= REQ_CNT`.
- `GAP_TIMEOUT`, 1024: idle cycles without `ts_i_vld` before the run is abandoned.

Ports:
- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush from the LTSSM on any state change.
- `ts_i`  in  128  received ordered set. Symbol k is at `[8k+7:8k]`.
- `ts_i_vld`  in  1  `ts_i` is valid this cycle (single-cycle qualifier).
- `ts_type`  out  2  type of the last good TS: 00 none, 01 TS1, 10 TS2.
- `link_num`, `lane_num`, `n_fts`, `rate_id`, `train_ctrl`  out  8 each  symbols 1..5 of the last good TS.
- `consec_cnt`  out  CNT_W  current run length.
- `ts_lock`  out  1  level; high while in LOCKED.
- `ts_lock_pulse`  out  1  one cycle on entry to LOCKED.
- `ts_err`  out  1  one-cycle pulse for a malformed TS.
- `gap_timeout`  out  1  one-cycle pulse when the gap watchdog expires.
- `err_cnt`  out  16  malformed-TS count. Present only with `TS_RX_ERR_CNT_EN`.

## Operation
- A TS is good when symbol 0 is COM (8'hBC) and symbols 6..15 are all 8'h4A (TS1) or all 8'h45 (TS2). Any other TS is malformed.
- Identical: same type as the held TS and symbols 1..5 equal to the held fields.
- States:
  - IDLE: no held TS.
  - TRACK: counting a run.
  - LOCKED: run length ≥ `REQ_CNT`.
- Transitions on a good TS:
  - IDLE → TRACK: capture fields, count = 1.
  - TRACK, identical: count + 1. When the count reaches `REQ_CNT`, go to LOCKED and pulse `ts_lock_pulse`.
  - TRACK or LOCKED, non-identical: capture the new fields, count = 1, go to TRACK.
  - LOCKED, identical: count saturates at `2**CNT_W - 1`; state stays LOCKED.
- Transitions on a malformed TS:
  - Pulse `ts_err`, count = 0, go to IDLE.
  - Fields and `ts_type` hold their last good values.
- Gap watchdog:
  - Increments each cycle without `ts_i_vld` in TRACK or LOCKED. Resets on any `ts_i_vld`.
  - On reaching `GAP_TIMEOUT`: pulse `gap_timeout`, count = 0, go to IDLE. Fields are retained.
- `clear`: go to IDLE, count = 0, watchdog = 0, `ts_type` = 00. Fields are not cleared.
- `clear` and `ts_i_vld` in the same cycle: `clear` wins and the TS is discarded.
- Malformed TS and watchdog expiry in the same cycle: cannot occur, because `ts_i_vld` resets the watchdog.

## Timing
- Every output is registered. The update appears on the cycle after the `ts_i_vld` sample.
- With back-to-back identical TS starting at cycle 0, `ts_lock` rises at cycle `REQ_CNT`.
- Pulses (`ts_lock_pulse`, `ts_err`, `gap_timeout`) last exactly one cycle.
- `ts_i_vld` may be asserted every cycle, or with arbitrary gaps shorter than `GAP_TIMEOUT`.
- Reset values:
  - State IDLE.
  - All fields, `ts_type`, `consec_cnt`, `err_cnt` = 0.
  - All flags and pulses = 0.
- Reset asserted mid-run forces reset values immediately (asynchronously). Nothing is retained.

## Configuration
- `TS_RX_ERR_CNT_EN` defined:
  - `err_cnt` port and its register exist.
  - Increments on each `ts_err` and saturates at 16'hFFFF.
  - Cleared only by `rst`; `clear` does not affect it.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `ltssm_pkg` holds:
  - Constants COM 8'hBC, TS1_ID 8'h4A, TS2_ID 8'h45, PAD 8'hF7.
  - `ts_type` encodings.
  - Symbol index constants.
- One sub-module, `ts_field_decode`. It is combinational: it splits `ts_i` into fields and produces the good, type and malformed indications.
- The top level holds the FSM, run counter, watchdog and output registers.

## Test plan
- 8 back-to-back TS1 with link 8'h00, lane 8'h02 → `ts_lock` rises on the cycle after the 8th. `ts_lock_pulse` fires once. `consec_cnt` = 8, `lane_num` = 8'h02.
- 5 TS1, then TS2 with the same fields → `consec_cnt` = 1, `ts_type` = 10, `ts_lock` stays 0.
- TS with symbol 0 = 8'h00 during TRACK at count 4 → one-cycle `ts_err`, state IDLE, count 0. `err_cnt` = 1 when `TS_RX_ERR_CNT_EN` is defined.
- 3 good TS, then no `ts_i_vld` for 1024 cycles → one `gap_timeout` pulse, count 0, `link_num` retained.
- `clear` and a good `ts_i_vld` in the same cycle while LOCKED → IDLE, count 0, `ts_type` = 00, the TS is not counted.
- 20 identical TS with `CNT_W` = 4 → count saturates at 15 and `ts_lock` stays high. Asynchronous `rst` mid-run → all outputs return to 0 without waiting for a clock edge.
